// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial bit link: receiver states, line levels
// and the even-parity helper.
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic IDLE_LEVEL  = 1'b0;
    localparam logic START_LEVEL = 1'b1;
    localparam logic STOP_LEVEL  = 1'b0;

    localparam int MAX_WIDTH = 32;

    // Callers zero-extend narrower words; the extra zeros do not change the parity.
    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] vec);
        even_parity = ^vec;
    endfunction

endpackage

// File: rtl/rx_word_buffer.sv
// One-entry valid/ready holding register. A load is taken when the slot is
// free or is being drained this cycle; otherwise the load is dropped and flagged.
module rx_word_buffer
    import serial_link_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] dout_data,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overflow
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             ovf_r;

    // Holding register, valid flag and one-cycle overflow pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            ovf_r <= 1'b0;
            if (load && (!valid_r || dout_ready)) begin
                data_r  <= word;
                valid_r <= 1'b1;
            end else if (load) begin
                ovf_r <= 1'b1;
            end else if (valid_r && dout_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign dout_data  = data_r;
    assign dout_valid = valid_r;
    assign overflow   = ovf_r;

endmodule

// File: rtl/serial_frame_receiver.sv
// Receive end of the serial bit link: frame FSM and deserializer feeding a
// one-entry word buffer, with single-cycle error pulses.
module serial_frame_receiver
    import serial_link_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             bit_en,
    output logic [WIDTH-1:0] dout_data,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             par_err,
    output logic             frame_err,
    output logic             overflow
);

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rx_state_t            state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [WIDTH-1:0]     shift_r, shift_s;
    logic                 par_bad_r, par_bad_s;
    logic                 par_err_r, frame_err_r;
    logic                 resolve_s, stop_bad_s, commit_s;
    logic [MAX_WIDTH-1:0] par_vec_s;

    // Next-state, shifter and parity latch; everything holds unless bit_en.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        shift_s    = shift_r;
        par_bad_s  = par_bad_r;
        resolve_s  = 1'b0;
        stop_bad_s = 1'b0;
        par_vec_s  = {MAX_WIDTH{1'b0}};
        par_vec_s[WIDTH-1:0] = shift_r;
        if (bit_en) begin
            case (state_r)
                IDLE: begin
                    if (din == START_LEVEL) begin
                        state_s   = DATA;
                        cnt_s     = {CNT_W{1'b0}};
                        par_bad_s = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                DATA: begin
                    shift_s = {shift_r[WIDTH-2:0], din};
                    cnt_s   = cnt_r + CNT_ONE;
                    if (cnt_r == LAST_BIT) begin
                        state_s = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        state_s = DATA;
                    end
                end
                PARITY: begin
                    par_bad_s = even_parity(par_vec_s) ^ din;
                    state_s   = STOP;
                end
                STOP: begin
                    resolve_s  = 1'b1;
                    stop_bad_s = (din != STOP_LEVEL);
                    state_s    = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    assign commit_s = resolve_s && !stop_bad_s && !par_bad_r;

    // FSM state, counter, shifter and the registered error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            shift_r     <= {WIDTH{1'b0}};
            par_bad_r   <= 1'b0;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            shift_r     <= shift_s;
            par_bad_r   <= par_bad_s;
            frame_err_r <= resolve_s && stop_bad_s;
            par_err_r   <= resolve_s && !stop_bad_s && par_bad_r;
        end
    end

    rx_word_buffer #(.WIDTH(WIDTH)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (commit_s),
        .word       (shift_r),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow)
    );

    assign busy      = (state_r != IDLE);
    assign par_err   = par_err_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: driver pushes expected words and
// pulses derived from each frame's contents; a negedge monitor pops and compares.
module tb_serial_frame_receiver;

    logic       clk = 1'b0;
    logic       rst_n, din, bit_en, dout_ready;
    logic [7:0] dout_data;
    logic       dout_valid, busy, par_err, frame_err, overflow;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct { int kind; int due; } pulse_t;             // 1 par, 2 frame, 3 ovf
    typedef struct { logic [7:0] data; int due; bit exact; } word_t;
    pulse_t pq[$];
    word_t  wq[$];

    serial_frame_receiver #(.WIDTH(8), .PARITY_EN(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .bit_en     (bit_en),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .par_err    (par_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse and every accepted word must match the scoreboard.
    always @(negedge clk) begin
        int kind_act;
        pulse_t p;
        word_t w;
        kind_act = frame_err ? 2 : (par_err ? 1 : (overflow ? 3 : 0));
        if (kind_act != 0) begin
            check("single_pulse", 32'(par_err) + 32'(frame_err) + 32'(overflow), 32'd1);
            if (pq.size() == 0) begin
                check("unexpected_pulse", 32'(kind_act), 32'd0);
            end else begin
                p = pq.pop_front();
                check("pulse_kind", 32'(kind_act), 32'(p.kind));
                check("pulse_time", 32'(cyc), 32'(p.due));
            end
        end
        if (dout_valid && dout_ready) begin
            if (wq.size() == 0) begin
                check("unexpected_word", 32'(wq.size()), 32'd1);
            end else begin
                w = wq.pop_front();
                check("word_data", 32'(dout_data), 32'(w.data));
                if (w.exact) check("word_time", 32'(cyc), 32'(w.due));
                else         check("word_late", 32'(cyc >= w.due), 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One line bit, then gap-1 cycles of bit_en=0 with junk on din.
    task automatic send_bit(input logic b, input int gap);
        din = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        for (int i = 1; i < gap; i++) begin
            din = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] w, input bit par_flip, input bit stop_one,
                              input int gap, input bit exact, input bit ready_on_stop,
                              input bit expect_ovf);
        int due;
        pulse_t p;
        word_t  e;
        send_bit(1'b1, gap);
        for (int i = 7; i >= 0; i--) send_bit(w[i], gap);
        send_bit((^w) ^ par_flip, gap);
        due = cyc + 1;
        din = stop_one;
        bit_en = 1'b1;
        if (ready_on_stop) dout_ready = 1'b1;
        check("busy_at_stop", 32'(busy), 32'd1);
        tick();
        if (ready_on_stop) dout_ready = 1'b0;
        bit_en = 1'b0;
        din = 1'b0;
        check("busy_after_stop", 32'(busy), 32'd0);
        if (stop_one) begin
            p.kind = 2; p.due = due; pq.push_back(p);
        end else if (par_flip) begin
            p.kind = 1; p.due = due; pq.push_back(p);
        end else if (expect_ovf) begin
            p.kind = 3; p.due = due; pq.push_back(p);
        end else begin
            e.data = w; e.due = due; e.exact = exact; wq.push_back(e);
        end
        for (int i = 1; i < gap; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0; din = 1'b0; bit_en = 1'b0; dout_ready = 1'b0;
        tick(); tick();
        check("reset_outputs", 32'({dout_data, dout_valid, busy, par_err, frame_err, overflow}), 32'd0);
        rst_n = 1'b1;

        // Idle line: nothing may happen.
        bit_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_outputs", 32'({dout_valid, busy, par_err, frame_err, overflow}), 32'd0);
        end

        // Good frame, valid for exactly one cycle.
        dout_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        check("a5_valid", 32'(dout_valid), 32'd1);
        check("a5_data", 32'(dout_data), 32'hA5);
        tick();
        check("a5_one_cycle", 32'(dout_valid), 32'd0);

        // Parity and framing errors drop the word.
        send_frame(8'h3C, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        tick();
        check("par_no_word", 32'(dout_valid), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        tick();
        check("frame_no_word", 32'(dout_valid), 32'd0);

        // Overflow: buffer full, second word dropped.
        dout_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1);
        tick(); tick();
        check("ovf_valid_held", 32'(dout_valid), 32'd1);
        check("ovf_data_held", 32'(dout_data), 32'h11);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("ovf_drained", 32'(dout_valid), 32'd0);

        // Drain on the same cycle as the second commit.
        send_frame(8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        check("swap_valid", 32'(dout_valid), 32'd1);
        check("swap_data", 32'(dout_data), 32'h22);
        tick();
        dout_ready = 1'b1;
        tick();

        // Gapped bit_en, one strobe in four.
        send_frame(8'h81, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0);
        tick();

        // Reset mid-frame, then a clean frame.
        bit_en = 1'b1;
        send_bit(1'b1, 1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_valid", 32'(dout_valid), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);

        // Randomized frames with the consumer always ready.
        for (int n = 0; n < 40; n++) begin
            int idle;
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 5) == 0), $urandom_range(1, 3), 1'b1, 1'b0, 1'b0);
            idle = $urandom_range(0, 2);
            for (int i = 0; i < idle; i++) begin
                bit_en = 1'($urandom_range(0, 1));
                din = 1'b0;
                tick();
            end
            bit_en = 1'b0;
        end

        repeat (5) tick();
        check("pulses_outstanding", 32'(pq.size()), 32'd0);
        check("words_outstanding", 32'(wq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Receive end of the team's serial bit link. Consumes a framed single-bit stream (start bit, WIDTH data bits MSB first, optional even parity, stop bit), one bit per `bit_en` strobe.
- Deserializes each frame and presents the word on a one-entry valid/ready output buffer.
- Reports parity, framing and overflow errors as single-cycle pulses.
- Sits between the serial shift path and word-level consumers.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..32).
- PARITY_EN, 1, 1 = even parity bit follows the data bits; 0 = no parity bit.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- din  input  1  serial line; idles 0.
- bit_en  input  1  qualifies din; the line is sampled only on cycles with bit_en=1.
- dout_data  output  WIDTH  received word; first data bit received lands in MSB.
- dout_valid  output  1  buffer holds an unread word.
- dout_ready  input  1  consumer accepts the word when dout_valid & dout_ready.
- busy  output  1  1 in any state other than IDLE.
- par_err  output  1  one-cycle pulse: parity mismatch, frame dropped.
- frame_err  output  1  one-cycle pulse: stop bit was 1, frame dropped.
- overflow  output  1  one-cycle pulse: good frame dropped because the buffer stayed full.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE.
  - dout_data=0, dout_valid=0, busy=0, par_err=0, frame_err=0, overflow=0.
  - Bit counter and shift register cleared.
  - Reset overrides every other input in the same cycle.
  - A frame in progress is abandoned with no error pulse.
- Single clock, one state machine: IDLE, DATA, PARITY, STOP. Transitions happen only on cycles with bit_en=1; when bit_en=0, state, counter and shift register hold.
  - IDLE: din=1 is the start bit → DATA, counter=0. din=0 stays in IDLE.
  - DATA: shift register ← {shift[WIDTH-2:0], din}; counter+1. After the WIDTH-th bit → PARITY if PARITY_EN, else STOP.
  - PARITY: XOR of WIDTH data bits and din must be 0. The result is latched; the state always moves to STOP, so the frame is always consumed to full length.
  - STOP: din must be 0. Then → IDLE and the frame resolves.
- Frame resolution, on the edge that samples the stop bit; error priority is frame_err > par_err > overflow, and only one pulse fires per frame:
  - Stop bit = 1: frame_err=1 on the next cycle, word discarded.
  - Else if parity failed: par_err=1 on the next cycle, word discarded.
  - Else if the buffer is free (dout_valid=0), or is being drained this cycle (dout_valid & dout_ready): dout_data ← word and dout_valid=1 on the next cycle.
  - Else: overflow=1 on the next cycle; the new word is dropped and the buffered word is kept unchanged.
- Latency: 1 clk from the stop-bit sampling edge to dout_valid.
- Output handshake:
  - dout_data is stable while dout_valid=1 and not accepted.
  - Acceptance with no simultaneous commit → dout_valid=0 next cycle.
  - Acceptance and commit in the same cycle → dout_valid stays 1 with the new word, and no overflow pulse.
- Back-to-back frames: a start bit may arrive on the first bit_en after the stop bit; IDLE accepts it immediately.
- Error pulses are exactly one clk wide regardless of bit_en.
- busy=1 from the cycle after the start bit is sampled through the cycle the stop bit is sampled.

Decomposition:
- Shared package `serial_link_pkg`:
  - state enum (IDLE, DATA, PARITY, STOP);
  - constants IDLE_LEVEL=0, START_LEVEL=1, STOP_LEVEL=0;
  - parity helper function (even parity over a vector).
- One natural sub-module: `rx_word_buffer`, the one-entry valid/ready holding register with load/accept/overflow logic. The FSM and shifter stay in the top.

Test Plan (WIDTH=8, PARITY_EN=1, bit_en=1 every cycle unless stated):
1. Reset then idle: rst_n=0 for 2 clks, din=0 for 20 clks → all outputs 0, busy=0 throughout.
2. Good frame: serial 1, 0xA5 MSB first (1,0,1,0,0,1,0,1), parity 0, stop 0, with dout_ready=1 → dout_valid=1 with dout_data=0xA5 one clk after the stop bit, for exactly one cycle.
3. Error frames:
   - Frame 0x3C with parity bit 1 → par_err pulse for 1 clk, dout_valid stays 0.
   - Frame 0x3C with parity 0 and stop bit 1 → frame_err pulse only.
4. Overflow and simultaneous drain:
   - dout_ready=0; send 0x11 then 0x22 back-to-back → dout_data=0x11 held, overflow pulses once after the second stop bit.
   - Repeat with dout_ready=1 exactly on the cycle of the second commit → dout_valid stays 1, dout_data=0x22, no overflow.
5. Gapped bit_en (1 of every 4 cycles) with frame 0x81 → same result as scenario 2 with dout_data=0x81. State holds during bit_en=0.
6. Reset mid-frame: assert rst_n=0 after 4 data bits, release, then send 0x5A → no error pulses, dout_data=0x5A.
